// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side signals of the two-port data memory arbiter.
interface dmem_arbiter_if;
  logic        r0_valid;
  logic        r0_ready;
  logic        r0_we;
  logic [31:0] r0_addr;
  logic [31:0] r0_wdata;
  logic        r0_rvalid;
  logic [31:0] r0_rdata;
  logic        r0_err;

  logic        r1_valid;
  logic        r1_ready;
  logic        r1_we;
  logic [31:0] r1_addr;
  logic [31:0] r1_wdata;
  logic        r1_rvalid;
  logic [31:0] r1_rdata;
  logic        r1_err;

  logic        mem_en;
  logic        mem_r_w;
  logic [31:0] mem_address;
  logic [31:0] mem_in;
  logic [31:0] mem_out;

  // Arbiter side
  modport slave (
    input  r0_valid, r0_we, r0_addr, r0_wdata,
    output r0_ready, r0_rvalid, r0_rdata, r0_err,
    input  r1_valid, r1_we, r1_addr, r1_wdata,
    output r1_ready, r1_rvalid, r1_rdata, r1_err,
    output mem_en, mem_r_w, mem_address, mem_in,
    input  mem_out
  );

  // Requester/memory side
  modport master (
    output r0_valid, r0_we, r0_addr, r0_wdata,
    input  r0_ready, r0_rvalid, r0_rdata, r0_err,
    output r1_valid, r1_we, r1_addr, r1_wdata,
    input  r1_ready, r1_rvalid, r1_rdata, r1_err,
    input  mem_en, mem_r_w, mem_address, mem_in,
    output mem_out
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port, 1-cycle-latency data memory.
// One access issued per cycle; the response returns on the issuing port one
// cycle later. Out-of-range accesses are accepted but flagged with err.
module dmem_arbiter #(
  parameter int unsigned DEPTH      = 2048,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  logic        last_grant_q, last_grant_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_port_q,  resp_port_d;
  logic        resp_we_q,    resp_we_d;
  logic        resp_err_q,   resp_err_d;

  logic        gnt_valid;
  logic        gnt_port;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_in_range;

  // Grant selection: single requester wins; contention resolved by priority mode
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = 1'b0;
    if (!rst) begin
      if (bus.r0_valid && bus.r1_valid) begin
        gnt_valid = 1'b1;
        gnt_port  = FIXED_PRIO ? 1'b0 : ~last_grant_q;
      end else if (bus.r0_valid) begin
        gnt_valid = 1'b1;
        gnt_port  = 1'b0;
      end else if (bus.r1_valid) begin
        gnt_valid = 1'b1;
        gnt_port  = 1'b1;
      end
    end
  end

  // Issue path: mux the granted request onto the memory, next-state for trackers
  always_comb begin
    sel_we       = gnt_port ? bus.r1_we    : bus.r0_we;
    sel_addr     = gnt_port ? bus.r1_addr  : bus.r0_addr;
    sel_wdata    = gnt_port ? bus.r1_wdata : bus.r0_wdata;
    sel_in_range = (sel_addr < 32'(DEPTH));

    bus.r0_ready    = gnt_valid && !gnt_port;
    bus.r1_ready    = gnt_valid &&  gnt_port;

    bus.mem_en      = 1'b0;
    bus.mem_r_w     = 1'b0;
    bus.mem_address = '0;
    bus.mem_in      = '0;
    if (gnt_valid && sel_in_range) begin
      bus.mem_en      = 1'b1;
      bus.mem_r_w     = sel_we;
      bus.mem_address = sel_addr;
      bus.mem_in      = sel_wdata;
    end

    last_grant_d = gnt_valid ? gnt_port : last_grant_q;
    resp_valid_d = gnt_valid;
    resp_port_d  = gnt_port;
    resp_we_d    = sel_we;
    resp_err_d   = gnt_valid && !sel_in_range;
  end

  // Round-robin pointer and response tracking register
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_port_q  <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      resp_we_q    <= resp_we_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Response routing; rst gates the pending response so nothing leaks during reset
  always_comb begin
    logic        rv0, rv1;
    logic [31:0] rd;
    rv0 = resp_valid_q && !resp_port_q && !rst;
    rv1 = resp_valid_q &&  resp_port_q && !rst;
    rd  = (!resp_we_q && !resp_err_q) ? bus.mem_out : '0;

    bus.r0_rvalid = rv0;
    bus.r0_rdata  = rv0 ? rd : '0;
    bus.r0_err    = rv0 && resp_err_q;
    bus.r1_rvalid = rv1;
    bus.r1_rdata  = rv1 ? rd : '0;
    bus.r1_err    = rv1 && resp_err_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a round-robin instance (a) and a
// fixed-priority instance (b), each with a behavioural 1-cycle memory.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if a ();
  dmem_arbiter_if b ();

  dmem_arbiter #(.DEPTH(2048), .FIXED_PRIO(1'b0)) dut_rr (.clk(clk), .rst(rst), .bus(a));
  dmem_arbiter #(.DEPTH(2048), .FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .rst(rst), .bus(b));

  logic [31:0] mem_a [2048];
  logic [31:0] mem_b [2048];

  // Behavioural single-port memories with registered read data
  always @(posedge clk) begin
    if (a.mem_en) begin
      if (a.mem_r_w) mem_a[a.mem_address[10:0]] <= a.mem_in;
      else           a.mem_out <= mem_a[a.mem_address[10:0]];
    end
    if (b.mem_en) begin
      if (b.mem_r_w) mem_b[b.mem_address[10:0]] <= b.mem_in;
      else           b.mem_out <= mem_b[b.mem_address[10:0]];
    end
  end

  int tests = 0;
  int fails = 0;

  // Expected responses {err, rdata}; index 0/1 = a ports, 2/3 = b ports
  logic [32:0] sbq [4][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic mon(input int p, input logic rv, input logic [31:0] rd, input logic er);
    logic [32:0] e;
    if (rv) begin
      if (sbq[p].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp_unexpected_p%0d: got rvalid=1 required none (rdata %h)", p, rd);
      end else begin
        e = sbq[p].pop_front();
        chk($sformatf("rdata_p%0d", p), rd, e[31:0]);
        chk($sformatf("err_p%0d", p), {31'b0, er}, {31'b0, e[32]});
      end
    end else begin
      chk($sformatf("idle_p%0d", p), {31'b0, er} | rd, 32'h0);
    end
  endtask

  // Monitor: compares every presented response against the scoreboard
  always @(negedge clk) begin
    mon(0, a.r0_rvalid, a.r0_rdata, a.r0_err);
    mon(1, a.r1_rvalid, a.r1_rdata, a.r1_err);
    mon(2, b.r0_rvalid, b.r0_rdata, b.r0_err);
    mon(3, b.r1_rvalid, b.r1_rdata, b.r1_err);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[0] = 32'hA0A0A0A0;
    mem_a[6] = 32'h06060606;
    mem_a[7] = 32'h07070707;
    mem_b[6] = 32'h06060606;
    mem_b[7] = 32'h07070707;
    {a.r0_valid, a.r0_we, a.r0_addr, a.r0_wdata} = '0;
    {a.r1_valid, a.r1_we, a.r1_addr, a.r1_wdata} = '0;
    {b.r0_valid, b.r0_we, b.r0_addr, b.r0_wdata} = '0;
    {b.r1_valid, b.r1_we, b.r1_addr, b.r1_wdata} = '0;
    a.mem_out = '0;
    b.mem_out = '0;

    // Reset state, with a request pending to show ready is held low
    rst = 1'b1;
    a.r0_valid = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_ready0", {31'b0, a.r0_ready}, 32'h0);
    chk("rst_mem_en", {31'b0, a.mem_en}, 32'h0);
    chk("rst_mem_addr", a.mem_address, 32'h0);
    tick();
    rst = 1'b0;
    a.r0_valid = 1'b0;

    // Write addr 5
    a.r0_valid = 1'b1; a.r0_we = 1'b1; a.r0_addr = 32'd5; a.r0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_ready0", {31'b0, a.r0_ready}, 32'h1);
    chk("wr_mem_en", {31'b0, a.mem_en}, 32'h1);
    chk("wr_mem_r_w", {31'b0, a.mem_r_w}, 32'h1);
    chk("wr_mem_addr", a.mem_address, 32'd5);
    chk("wr_mem_in", a.mem_in, 32'hDEADBEEF);
    sbq[0].push_back({1'b0, 32'h0});
    tick();

    // Read-after-write, same address
    a.r0_we = 1'b0;
    @(negedge clk);
    chk("raw_ready0", {31'b0, a.r0_ready}, 32'h1);
    chk("raw_mem_r_w", {31'b0, a.mem_r_w}, 32'h0);
    sbq[0].push_back({1'b0, 32'hDEADBEEF});
    tick();
    a.r0_valid = 1'b0;
    tick();

    // Reset pointer so contention starts with port 0
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Round-robin contention: r0 reads 6, r1 reads 7
    a.r0_valid = 1'b1; a.r0_we = 1'b0; a.r0_addr = 32'd6;
    a.r1_valid = 1'b1; a.r1_we = 1'b0; a.r1_addr = 32'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rr_ready0_c%0d", i), {31'b0, a.r0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("rr_ready1_c%0d", i), {31'b0, a.r1_ready}, (i % 2 == 0) ? 32'h0 : 32'h1);
      chk($sformatf("rr_addr_c%0d", i), a.mem_address, (i % 2 == 0) ? 32'd6 : 32'd7);
      if (i % 2 == 0) sbq[0].push_back({1'b0, 32'h06060606});
      else            sbq[1].push_back({1'b0, 32'h07070707});
      tick();
    end
    a.r0_valid = 1'b0;
    a.r1_valid = 1'b0;
    tick();

    // Out-of-range write must not reach memory (would alias addr 0)
    a.r1_valid = 1'b1; a.r1_we = 1'b1; a.r1_addr = 32'd2048; a.r1_wdata = 32'h12345678;
    @(negedge clk);
    chk("oor_wr_ready1", {31'b0, a.r1_ready}, 32'h1);
    chk("oor_wr_mem_en", {31'b0, a.mem_en}, 32'h0);
    sbq[1].push_back({1'b1, 32'h0});
    tick();
    // Out-of-range read
    a.r1_we = 1'b0;
    @(negedge clk);
    chk("oor_rd_ready1", {31'b0, a.r1_ready}, 32'h1);
    chk("oor_rd_mem_en", {31'b0, a.mem_en}, 32'h0);
    sbq[1].push_back({1'b1, 32'h0});
    tick();
    // Addr 0 still holds its original contents
    a.r1_addr = 32'd0;
    @(negedge clk);
    sbq[1].push_back({1'b0, 32'hA0A0A0A0});
    tick();
    a.r1_valid = 1'b0;
    tick();

    // Reset during the response cycle suppresses the response
    a.r0_valid = 1'b1; a.r0_we = 1'b0; a.r0_addr = 32'd6;
    @(negedge clk);
    chk("pre_rst_ready0", {31'b0, a.r0_ready}, 32'h1);
    tick();
    rst = 1'b1;
    a.r0_valid = 1'b0;
    @(negedge clk);
    chk("rst_rvalid0_during", {31'b0, a.r0_rvalid}, 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rvalid0_after", {31'b0, a.r0_rvalid}, 32'h0);
    a.r0_valid = 1'b1; a.r0_addr = 32'd6;
    a.r1_valid = 1'b1; a.r1_we = 1'b0; a.r1_addr = 32'd7;
    #1;
    chk("post_rst_ready0", {31'b0, a.r0_ready}, 32'h1);
    chk("post_rst_ready1", {31'b0, a.r1_ready}, 32'h0);
    sbq[0].push_back({1'b0, 32'h06060606});
    tick();
    @(negedge clk);
    chk("post_rst2_ready1", {31'b0, a.r1_ready}, 32'h1);
    sbq[1].push_back({1'b0, 32'h07070707});
    tick();
    a.r0_valid = 1'b0;
    a.r1_valid = 1'b0;
    tick();

    // Fixed priority: port 0 always wins while valid
    b.r0_valid = 1'b1; b.r0_we = 1'b0; b.r0_addr = 32'd6;
    b.r1_valid = 1'b1; b.r1_we = 1'b0; b.r1_addr = 32'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("fp_ready0_c%0d", i), {31'b0, b.r0_ready}, 32'h1);
      chk($sformatf("fp_ready1_c%0d", i), {31'b0, b.r1_ready}, 32'h0);
      sbq[2].push_back({1'b0, 32'h06060606});
      tick();
    end
    b.r0_valid = 1'b0;
    @(negedge clk);
    chk("fp_ready1_free", {31'b0, b.r1_ready}, 32'h1);
    sbq[3].push_back({1'b0, 32'h07070707});
    tick();
    b.r1_valid = 1'b0;
    tick();
    tick();

    for (int p = 0; p < 4; p++)
      chk($sformatf("sb_drained_p%0d", p), sbq[p].size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
